// File: rtl/rr_mux_n.sv
// N-channel arbitrated mux with a single registered valid/ready output stage.
// Round-robin or fixed-priority grant; one word per cycle when out_ready is high.
module rr_mux_n #(
  parameter int WIDTH    = 64,
  parameter int CHANNELS = 4,
  parameter int RR       = 1,
  parameter int SELW     = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SELW-1:0]           out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic [WIDTH-1:0] chan_data [CHANNELS];
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_chan_q, out_chan_d;
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  ptr_q, ptr_d;

  logic             load;
  logic             found;
  logic             gnt;
  logic [SELW-1:0]  sel;
  logic [SELW-1:0]  idx;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_unpack
    assign chan_data[g] = in_data[g*WIDTH +: WIDTH];
  end

  // Search covers all CHANNELS positions, so the ptr channel
  // itself is reached last and can be re-granted.
  always_comb begin
    load  = ~out_valid_q | out_ready;
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (RR != 0)
        idx = SELW'((int'(ptr_q) + 1 + k) % CHANNELS);
      else
        idx = SELW'(k);
      if (!found && in_valid[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
    gnt = load & found & ~reset;
  end

  always_comb begin
    in_ready = '0;
    if (gnt)
      in_ready[sel] = 1'b1;
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (gnt) begin
      out_data_d  = chan_data[sel];
      out_chan_d  = sel;
      out_valid_d = 1'b1;
      ptr_d       = sel;
    end else if (load) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= SELW'(CHANNELS - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_mux_n.sv
// Directed bench for rr_mux_n: a round-robin and a fixed-priority
// instance share stimulus; each section checks one of them.
module tb_rr_mux_n;

  localparam int W = 16;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   vld;
  logic           ordy;

  logic [N-1:0]   rr_rdy, fp_rdy;
  logic [W-1:0]   rr_data, fp_data;
  logic [1:0]     rr_chan, fp_chan;
  logic           rr_ov, fp_ov;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rr_mux_n #(.WIDTH(W), .CHANNELS(N), .RR(1)) dut_rr (
    .clk(clk), .reset(rst), .in_data(in_data),
    .in_valid(vld), .in_ready(rr_rdy),
    .out_data(rr_data), .out_chan(rr_chan),
    .out_valid(rr_ov), .out_ready(ordy)
  );

  rr_mux_n #(.WIDTH(W), .CHANNELS(N), .RR(0)) dut_fp (
    .clk(clk), .reset(rst), .in_data(in_data),
    .in_valid(vld), .in_ready(fp_rdy),
    .out_data(fp_data), .out_chan(fp_chan),
    .out_valid(fp_ov), .out_ready(ordy)
  );

  typedef struct {
    logic       r;
    logic [3:0] v;
    logic       o;
    logic [3:0] er;
    logic       eov;
    logic [1:0] ec;
    logic [15:0] ed;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  task automatic step(input bit fp, input logic r, input logic [3:0] v,
                      input logic o, input logic [3:0] er, input logic eov,
                      input logic [1:0] ec, input logic [15:0] ed,
                      input string nm);
    rst  = r;
    vld  = v;
    ordy = o;
    #1;
    chk({nm, ".in_ready"}, 16'(fp ? fp_rdy : rr_rdy), 16'(er));
    @(posedge clk);
    #1;
    chk({nm, ".out_valid"}, 16'(fp ? fp_ov : rr_ov), 16'(eov));
    chk({nm, ".out_chan"}, 16'(fp ? fp_chan : rr_chan), 16'(ec));
    chk({nm, ".out_data"}, fp ? fp_data : rr_data, ed);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 16'h0};
    tbl[1]  = '{1'b1, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 16'h0};
    tbl[2]  = '{1'b0, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0, 16'hA0};
    tbl[3]  = '{1'b0, 4'hF, 1'b1, 4'h2, 1'b1, 2'd1, 16'hA1};
    tbl[4]  = '{1'b0, 4'hF, 1'b1, 4'h4, 1'b1, 2'd2, 16'hA2};
    tbl[5]  = '{1'b0, 4'hF, 1'b1, 4'h8, 1'b1, 2'd3, 16'hA3};
    tbl[6]  = '{1'b0, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0, 16'hA0};
    tbl[7]  = '{1'b0, 4'hF, 1'b1, 4'h2, 1'b1, 2'd1, 16'hA1};
    tbl[8]  = '{1'b0, 4'hF, 1'b1, 4'h4, 1'b1, 2'd2, 16'hA2};
    tbl[9]  = '{1'b0, 4'hF, 1'b1, 4'h8, 1'b1, 2'd3, 16'hA3};
    tbl[10] = '{1'b0, 4'h8, 1'b1, 4'h8, 1'b1, 2'd3, 16'hA3};
    tbl[11] = '{1'b0, 4'h8, 1'b1, 4'h8, 1'b1, 2'd3, 16'hA3};
    tbl[12] = '{1'b0, 4'h8, 1'b1, 4'h8, 1'b1, 2'd3, 16'hA3};
    tbl[13] = '{1'b0, 4'hA, 1'b1, 4'h2, 1'b1, 2'd1, 16'hA1};
    tbl[14] = '{1'b0, 4'hA, 1'b1, 4'h8, 1'b1, 2'd3, 16'hA3};
    tbl[15] = '{1'b0, 4'hA, 1'b1, 4'h2, 1'b1, 2'd1, 16'hA1};
    tbl[16] = '{1'b0, 4'hA, 1'b1, 4'h8, 1'b1, 2'd3, 16'hA3};
    tbl[17] = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 2'd3, 16'hA3};

    in_data = {16'hA3, 16'hA2, 16'hA1, 16'hA0};
    rst  = 1'b1;
    vld  = '0;
    ordy = 1'b0;

    // reset, 8-cycle sweep, sparse wrap, alternation, drain
    for (int i = 0; i < 18; i++)
      step(0, tbl[i].r, tbl[i].v, tbl[i].o, tbl[i].er,
           tbl[i].eov, tbl[i].ec, tbl[i].ed, $sformatf("tbl%0d", i));

    // stall holds 'h1234 from channel 2, then same-cycle regrant
    in_data[47:32] = 16'h1234;
    step(0, 0, 4'h4, 0, 4'h4, 1, 2'd2, 16'h1234, "stall_load");
    for (int i = 0; i < 3; i++)
      step(0, 0, 4'h8, 0, 4'h0, 1, 2'd2, 16'h1234, "stall_hold");
    step(0, 0, 4'h8, 1, 4'h8, 1, 2'd3, 16'hA3, "stall_release");

    // move ptr to 0, stall, then reset must restore ptr
    step(0, 0, 4'hF, 1, 4'h1, 1, 2'd0, 16'hA0, "pre_rst");
    step(0, 0, 4'hF, 0, 4'h0, 1, 2'd0, 16'hA0, "pre_rst_stall");
    step(0, 1, 4'hF, 0, 4'h0, 0, 2'd0, 16'h0, "mid_rst");
    step(0, 0, 4'hF, 1, 4'h1, 1, 2'd0, 16'hA0, "post_rst");

    // fixed priority instance
    in_data[47:32] = 16'hA2;
    step(1, 1, 4'h6, 1, 4'h0, 0, 2'd0, 16'h0, "fp_rst");
    for (int i = 0; i < 3; i++)
      step(1, 0, 4'h6, 1, 4'h2, 1, 2'd1, 16'hA1, "fp_low");
    step(1, 0, 4'h4, 1, 4'h4, 1, 2'd2, 16'hA2, "fp_ch2");
    step(1, 0, 4'h6, 1, 4'h2, 1, 2'd1, 16'hA1, "fp_back");
    step(1, 0, 4'hF, 1, 4'h1, 1, 2'd0, 16'hA0, "fp_all");
    step(1, 0, 4'h0, 1, 4'h0, 0, 2'd0, 16'hA0, "fp_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_mux_n.md
Name: rr_mux_n

Overview:
- Parametrised N-channel, W-bit arbitrated multiplexer. It is the registered, handshaked successor of the team's 2:1 gate-level mux.
- Selects one of CHANNELS requesting input channels per cycle, using round-robin or fixed priority.
- Captures the selected word into a single output register stage with valid/ready flow control.
- Used to merge per-stage request streams, such as register-file write ports and memory requesters, onto one shared datapath.

Parameters:
- WIDTH, 64: data bits per channel.
- CHANNELS, 4: number of input channels. Legal range 2..16.
- RR, 1: arbitration mode. 1 selects round-robin; 0 selects fixed priority, where the lowest index wins.
- SELW, $clog2(CHANNELS): width of the channel-index output. Derived; do not override.

Ports:
- clk, input, 1: clock. All state changes on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- in_data, input, CHANNELS*WIDTH: packed channel data. Channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid, input, CHANNELS: per-channel request.
- in_ready, output, CHANNELS: per-channel grant/accept. One-hot or zero.
- out_data, output, WIDTH: registered selected word.
- out_chan, output, SELW: registered index of the source channel of out_data.
- out_valid, output, 1: output register holds a word.
- out_ready, input, 1: downstream accepts out_data this cycle.

Behaviour:
- Reset (sampled high at the edge):
  - out_valid=0, out_data=0, out_chan=0.
  - Priority pointer ptr=CHANNELS-1, so channel 0 has first priority after reset.
  - in_ready=0 combinationally while reset is high.
  - Reset mid-transfer discards the held word. No partial state survives.
- Load enable: load = ~out_valid | out_ready. The output stage can accept a new word in the same cycle its current word leaves.
- Grant (combinational):
  - When load=1 and in_valid!=0, exactly one in_ready bit is set.
  - When load=0 or in_valid==0, in_ready=0.
- Grant order, RR=1: search from channel (ptr+1) mod CHANNELS upward with wrap-around. The first channel with in_valid set wins.
- Grant order, RR=0: the lowest index with in_valid set wins. ptr is ignored but still updated.
- Transfer: in channel i occurs when in_valid[i] & in_ready[i]. At that edge:
  - out_data <= channel i data.
  - out_chan <= i.
  - out_valid <= 1.
  - ptr <= i.
- Drain: if load=1 and no channel requests, then out_valid <= 0 at the edge. out_data and out_chan hold their last values.
- Stall: if out_valid=1 and out_ready=0:
  - out_data, out_chan and out_valid are held stable.
  - ptr is unchanged and in_ready=0.
  - Upstream channels must hold in_valid and data until they are granted.
- Throughput and latency:
  - Throughput is one word per cycle with out_ready held high.
  - Latency is 1 cycle from the in_valid/in_ready handshake to out_valid.
- Fairness (RR=1): with all channels continuously valid and out_ready=1, grants cycle 0,1,...,CHANNELS-1,0,... Any continuously valid channel waits at most CHANNELS-1 transfers.
- Wrap-around: if ptr=CHANNELS-1, the search starts at 0. If only the ptr channel itself requests, it is granted again (search covers all CHANNELS positions).
- Combinational paths:
  - in_ready depends on in_valid, out_valid, out_ready, ptr and reset.
  - out_* depend only on registers.
  - Upstream logic must not make in_valid depend on in_ready.
- Data width: no arithmetic. Bits pass through unchanged. out_chan is zero-extended to SELW.

Test Plan:
- Reset check: assert reset 2 cycles with in_valid=4'b1111 → in_ready=0, out_valid=0, out_data=0, out_chan=0. Release reset → first grant is in_ready=4'b0001.
- Round-robin sweep: RR=1, all 4 channels valid with data 'hA0+i', out_ready=1 for 8 cycles → out_chan sequence 0,1,2,3,0,1,2,3 and out_data = matching 'hA0+i', back-to-back with no bubbles.
- Stall and hold: out_ready=0 for 3 cycles with out_valid=1 holding 'h1234 from channel 2 → out_data, out_chan and out_valid stable and in_ready=0. Raise out_ready → same-cycle grant of channel 3 if valid.
- Sparse wrap: only channel 3 valid, ptr=3 → channel 3 granted repeatedly. Then channels 1 and 3 valid → order 1,3,1,3.
- Fixed priority: RR=0, channels 1 and 2 continuously valid → channel 1 always granted. Channel 2 is granted only after in_valid[1] drops.
- Reset mid-stall: out_valid=1, out_ready=0, pulse reset one cycle → out_valid=0, ptr restored so the next grant with all channels valid is channel 0.
